// File: rtl/max_reduce_seq.sv
// rtl/max_reduce_seq.sv - stream max reducer driving an external two-operand compare unit
module max_reduce_seq #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             cu_start,
  output logic [WIDTH-1:0] cu_a,
  output logic [WIDTH-1:0] cu_b,
  input  logic [WIDTH-1:0] cu_result,
  input  logic             cu_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic             out_empty
);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    NEXT,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    OUT
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op;
  logic [LEN_W-1:0] remaining;

  // Operands are the accumulator and operand registers themselves, so they
  // stay put from LAUNCH until WAIT_HI folds the result back into acc.
  assign cu_a = acc;
  assign cu_b = op;

  // Sequencer FSM: all handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      op        <= '0;
      remaining <= '0;
      cmd_ready <= 1'b1;
      in_ready  <= 1'b0;
      cu_start  <= 1'b0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_empty <= 1'b0;
    end else begin
      cu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            if (cmd_len == '0) begin
              out_max   <= '0;
              out_empty <= 1'b1;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              out_empty <= 1'b0;
              in_ready  <= 1'b1;
              state     <= FIRST;
            end
          end
        end
        FIRST: begin
          if (in_valid) begin
            acc <= in_data;
            if (remaining != '0) begin
              remaining <= remaining - LEN_ONE;
            end
            if (remaining <= LEN_ONE) begin
              out_max   <= in_data;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= OUT;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (in_valid) begin
            op       <= in_data;
            in_ready <= 1'b0;
            cu_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_LO;
        end
        WAIT_LO: begin
          // A stale done=1 from the previous compare, or X after reset,
          // must not be mistaken for completion of this one.
          if (cu_done == 1'b0) begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (cu_done == 1'b1) begin
            acc <= cu_result;
            if (remaining != '0) begin
              remaining <= remaining - LEN_ONE;
            end
            if (remaining <= LEN_ONE) begin
              out_max   <= cu_result;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              in_ready <= 1'b1;
              state    <= NEXT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_reduce_seq.sv
// tb/tb_max_reduce_seq.sv - directed self-checking bench for max_reduce_seq with a compare unit model
module tb_max_reduce_seq;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        cu_start;
  logic [31:0] cu_a;
  logic [31:0] cu_b;
  logic [31:0] cu_result;
  logic        cu_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_max;
  logic        out_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] elems [0:3];

  max_reduce_seq #(.WIDTH(32), .LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cu_start  (cu_start),
    .cu_a      (cu_a),
    .cu_b      (cu_b),
    .cu_result (cu_result),
    .cu_done   (cu_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_empty (out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare unit model: start at E0, latch a/b and drop done at E1, done with max at E3.
  int          cu_phase;
  logic [31:0] la;
  logic [31:0] lb;
  always @(posedge clk) begin
    if (reset) begin
      cu_done   <= 1'bx;
      cu_result <= '0;
      cu_phase  <= 0;
    end else begin
      case (cu_phase)
        0: if (cu_start) cu_phase <= 1;
        1: begin la <= cu_a; lb <= cu_b; cu_done <= 1'b0; cu_phase <= 2; end
        2: cu_phase <= 3;
        default: begin cu_done <= 1'b1; cu_result <= (la > lb) ? la : lb; cu_phase <= 0; end
      endcase
    end
  end

  // Monitor: start pulse count/width, operand stability per compare window, out/cmd overlap.
  int          start_cnt   = 0;
  int          pulse_err   = 0;
  int          stab_err    = 0;
  int          overlap_err = 0;
  logic        prev_start  = 1'b0;
  logic        win         = 1'b0;
  logic [31:0] wa;
  logic [31:0] wb;
  always @(negedge clk) begin
    prev_start <= cu_start;
    if (out_valid && cmd_ready) overlap_err <= overlap_err + 1;
    if (reset) begin
      win <= 1'b0;
    end else if (cu_start) begin
      start_cnt <= start_cnt + 1;
      if (prev_start) pulse_err <= pulse_err + 1;
      win <= 1'b1;
      wa  <= cu_a;
      wb  <= cu_b;
    end else if (win) begin
      if (cu_a !== wa || cu_b !== wb) stab_err <= stab_err + 1;
      if (cu_done === 1'b1 && cu_phase == 0) win <= 1'b0;
    end
  end

  // Runs one job; lat = edges after the cmd edge until out_valid is seen (-1 on timeout).
  task automatic do_job(input int len, input int gap, input int hold,
                        output int lat, output logic [31:0] mx, output logic emp,
                        output int instab, output int rdy_bad, output int inr_seen);
    int idx;
    int gapc;
    int n;
    bit hs;
    bit fin;
    idx = 0; gapc = 0; hs = 0; fin = 0;
    lat = -1; instab = 0; rdy_bad = 0; inr_seen = 0;
    mx = '0; emp = 1'b0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1;
    cmd_len   = len[15:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!fin && n < 3000) begin
      if (hs) begin idx++; gapc = 0; end
      if (out_valid) begin
        lat = n; fin = 1;
        mx = out_max; emp = out_empty;
      end else begin
        if (in_ready) inr_seen++;
        if (in_ready && idx < len && gapc < gap) begin
          gapc++; in_valid = 1'b0;
        end else if (idx < len) begin
          in_valid = 1'b1; in_data = elems[idx];
        end else begin
          in_valid = 1'b0;
        end
        hs = in_valid && in_ready;
        @(negedge clk);
        n++;
      end
    end
    in_valid = 1'b0;
    if (fin) begin
      for (int i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b1 || out_max !== mx || out_empty !== emp) instab++;
        if (cmd_ready !== 1'b0) rdy_bad++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready: got %b expected 1", tag, cmd_ready); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready: got %b expected 0", tag, in_ready); end
    n_checks++; if (cu_start !== 1'b0) begin n_fail++; $display("FAIL %s cu_start: got %b expected 0", tag, cu_start); end
    n_checks++; if (cu_a !== 32'h0) begin n_fail++; $display("FAIL %s cu_a: got %h expected 0", tag, cu_a); end
    n_checks++; if (cu_b !== 32'h0) begin n_fail++; $display("FAIL %s cu_b: got %h expected 0", tag, cu_b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s out_valid: got %b expected 0", tag, out_valid); end
    n_checks++; if (out_max !== 32'h0) begin n_fail++; $display("FAIL %s out_max: got %h expected 0", tag, out_max); end
    n_checks++; if (out_empty !== 1'b0) begin n_fail++; $display("FAIL %s out_empty: got %b expected 0", tag, out_empty); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_single();
    int lat; logic [31:0] mx; logic emp; int ins; int rb; int irs; int s0;
    s0 = start_cnt;
    elems[0] = 32'h0000002A;
    do_job(1, 0, 0, lat, mx, emp, ins, rb, irs);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL single latency: got %0d expected 1", lat); end
    n_checks++; if (mx !== 32'h2A) begin n_fail++; $display("FAIL single max: got %h expected 0000002a", mx); end
    n_checks++; if (emp !== 1'b0) begin n_fail++; $display("FAIL single empty: got %b expected 0", emp); end
    n_checks++; if (start_cnt - s0 != 0) begin n_fail++; $display("FAIL single starts: got %0d expected 0", start_cnt - s0); end
  endtask

  task automatic test_four();
    int lat; logic [31:0] mx; logic emp; int ins; int rb; int irs; int s0; int p0; int st0;
    s0 = start_cnt; p0 = pulse_err; st0 = stab_err;
    elems[0] = 32'd5; elems[1] = 32'd9; elems[2] = 32'd3; elems[3] = 32'd9;
    do_job(4, 0, 0, lat, mx, emp, ins, rb, irs);
    n_checks++; if (lat != 19) begin n_fail++; $display("FAIL four latency: got %0d expected 19", lat); end
    n_checks++; if (mx !== 32'd9) begin n_fail++; $display("FAIL four max: got %h expected 00000009", mx); end
    n_checks++; if (emp !== 1'b0) begin n_fail++; $display("FAIL four empty: got %b expected 0", emp); end
    n_checks++; if (start_cnt - s0 != 3) begin n_fail++; $display("FAIL four starts: got %0d expected 3", start_cnt - s0); end
    n_checks++; if (pulse_err - p0 != 0) begin n_fail++; $display("FAIL four pulse_width: got %0d long pulses expected 0", pulse_err - p0); end
    n_checks++; if (stab_err - st0 != 0) begin n_fail++; $display("FAIL four operand_stable: got %0d changes expected 0", stab_err - st0); end
  endtask

  task automatic test_empty();
    int lat; logic [31:0] mx; logic emp; int ins; int rb; int irs;
    do_job(0, 0, 0, lat, mx, emp, ins, rb, irs);
    n_checks++; if (lat != 0) begin n_fail++; $display("FAIL empty latency: got %0d expected 0 (next cycle)", lat); end
    n_checks++; if (mx !== 32'h0) begin n_fail++; $display("FAIL empty max: got %h expected 0", mx); end
    n_checks++; if (emp !== 1'b1) begin n_fail++; $display("FAIL empty flag: got %b expected 1", emp); end
    n_checks++; if (irs != 0) begin n_fail++; $display("FAIL empty in_ready: got %0d high cycles expected 0", irs); end
  endtask

  task automatic test_unsigned_gap();
    int lat; logic [31:0] mx; logic emp; int ins; int rb; int irs; int s0; int st0;
    s0 = start_cnt; st0 = stab_err;
    elems[0] = 32'h00000001; elems[1] = 32'hFFFFFFFF; elems[2] = 32'h80000000;
    do_job(3, 5, 0, lat, mx, emp, ins, rb, irs);
    n_checks++; if (mx !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL gap max: got %h expected ffffffff", mx); end
    n_checks++; if (lat != 1 + 5 + 2 * (6 + 5)) begin n_fail++; $display("FAIL gap latency: got %0d expected 28", lat); end
    n_checks++; if (start_cnt - s0 != 2) begin n_fail++; $display("FAIL gap starts: got %0d expected 2", start_cnt - s0); end
    n_checks++; if (stab_err - st0 != 0) begin n_fail++; $display("FAIL gap operand_stable: got %0d changes expected 0", stab_err - st0); end
  endtask

  task automatic test_out_hold();
    int lat; logic [31:0] mx; logic emp; int ins; int rb; int irs;
    elems[0] = 32'd3; elems[1] = 32'd8;
    do_job(2, 0, 10, lat, mx, emp, ins, rb, irs);
    n_checks++; if (mx !== 32'd8) begin n_fail++; $display("FAIL hold max: got %h expected 00000008", mx); end
    n_checks++; if (ins != 0) begin n_fail++; $display("FAIL hold stable: got %0d changed cycles expected 0", ins); end
    n_checks++; if (rb != 0) begin n_fail++; $display("FAIL hold cmd_ready: got %0d high cycles expected 0", rb); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hold idle cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold idle out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] mx; logic emp; int ins; int rb; int irs;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 16'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd10;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    elems[0] = 32'd7; elems[1] = 32'd4;
    do_job(2, 0, 0, lat, mx, emp, ins, rb, irs);
    n_checks++; if (mx !== 32'd7) begin n_fail++; $display("FAIL post_reset max: got %h expected 00000007", mx); end
    n_checks++; if (lat != 7) begin n_fail++; $display("FAIL post_reset latency: got %0d expected 7", lat); end
  endtask

  task automatic test_no_overlap();
    n_checks++; if (overlap_err != 0) begin n_fail++; $display("FAIL overlap: got %0d cycles with out_valid and cmd_ready expected 0", overlap_err); end
    n_checks++; if (pulse_err != 0) begin n_fail++; $display("FAIL pulse_width total: got %0d expected 0", pulse_err); end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_four();
    test_empty();
    test_unsigned_gap();
    test_out_hold();
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_no_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
